// File: rtl/irq_pkg.sv
// Shared definitions for the peripheral interrupt controller:
// default line count, register word offsets and the FSM state type.
package irq_pkg;

    localparam int NUM_IRQ_DEFAULT = 6;

    localparam logic [1:0] IRQ_PEND   = 2'd0;
    localparam logic [1:0] IRQ_MASK   = 2'd1;
    localparam logic [1:0] IRQ_MODE   = 2'd2;
    localparam logic [1:0] IRQ_ACTIVE = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE,
        DROP
    } irq_state_t;

endpackage

// File: rtl/irq_sync.sv
// Single-line request synchroniser with rising-edge detection.
// s is the last synchroniser stage; rise is high for one cycle when s goes 0->1.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   s_d;

    // Shift the raw request through the synchroniser and keep one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], req};
            s_d   <= chain[SYNC_STAGES-1];
        end
    end

    assign s    = chain[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/irq_ctrl.sv
// Peripheral interrupt controller feeding the CP0 hardware interrupt lines.
// Latches synchronised requests as pending bits (edge or level), masks them,
// and holds the resulting lines towards CP0 until exl is raised or a timeout
// forces a drop/re-assert so CP0 sees a fresh 0->1 change.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               exl,
    input  logic [1:0]         addr,
    input  logic               we,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    output logic [NUM_IRQ-1:0] interrupt
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] act;
    logic [NUM_IRQ-1:0] snap;
    logic [NUM_IRQ-1:0] w1c;
    logic [2:0]         act_idx;
    logic [TMO_W-1:0]   tmo;
    irq_state_t         state;
    logic               unused_wd;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .req  (irq_req[i]),
            .s    (s[i]),
            .rise (rise[i])
        );
    end

    assign w1c       = (we && addr == IRQ_PEND) ? wd[NUM_IRQ-1:0] : '0;
    assign act       = pend & mask;
    assign unused_wd = ^wd[31:NUM_IRQ];

    // Pending bits: edge lines latch on rise and clear on W1C (rise wins), level lines follow s
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (mode[i]) begin
                    if (rise[i]) begin
                        pend[i] <= 1'b1;
                    end else if (w1c[i]) begin
                        pend[i] <= 1'b0;
                    end
                end else begin
                    pend[i] <= s[i];
                end
            end
        end
    end

    // MASK and MODE configuration registers; only the low NUM_IRQ bits exist
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            mode <= '0;
        end else if (we) begin
            if (addr == IRQ_MASK) begin
                mask <= wd[NUM_IRQ-1:0];
            end
            if (addr == IRQ_MODE) begin
                mode <= wd[NUM_IRQ-1:0];
            end
        end
    end

    // Priority encoder: lowest-numbered active line wins
    always_comb begin
        act_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act[i]) begin
                act_idx = 3'(i);
            end
        end
    end

    // Register read mux
    always_comb begin
        rd = '0;
        case (addr)
            IRQ_PEND:   rd[NUM_IRQ-1:0] = pend;
            IRQ_MASK:   rd[NUM_IRQ-1:0] = mask;
            IRQ_MODE:   rd[NUM_IRQ-1:0] = mode;
            IRQ_ACTIVE: begin
                rd[31]  = |act;
                rd[2:0] = act_idx;
            end
            default:    rd = '0;
        endcase
    end

    // Handshake FSM towards CP0 with registered interrupt lines and acknowledge timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            tmo       <= '0;
            interrupt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    interrupt <= '0;
                    if (|act && !exl) begin
                        snap      <= act;
                        tmo       <= '0;
                        interrupt <= act;
                        state     <= ASSERT;
                    end
                end
                ASSERT: begin
                    snap <= snap | act;
                    if (exl) begin
                        interrupt <= '0;
                        state     <= SERVICE;
                    end else if (tmo == TMO_LAST) begin
                        interrupt <= '0;
                        state     <= DROP;
                    end else begin
                        tmo       <= tmo + 1'b1;
                        interrupt <= snap | act;
                    end
                end
                SERVICE: begin
                    interrupt <= '0;
                    if (!exl) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    interrupt <= '0;
                    state     <= IDLE;
                end
                default: begin
                    interrupt <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized
// level/edge traffic checked against a register-level behavioural model.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  irq_req = '0;
    logic        exl = 1'b0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic [5:0]  interrupt;

    int n_cmp = 0;
    int n_bad = 0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_IRQ     (6),
        .SYNC_STAGES (2),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_req   (irq_req),
        .exl       (exl),
        .addr      (addr),
        .we        (we),
        .wd        (wd),
        .rd        (rd),
        .interrupt (interrupt)
    );

    // Advance n clock edges and land 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick(1);
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd;
    endtask

    task automatic do_reset();
        exl     = 1'b0;
        irq_req = '0;
        we      = 1'b0;
        rst     = 1'b1;
        tick(2);
        rst     = 1'b0;
        tick(1);
    endtask

    // ACTIVE register contents derived from the priority rule: lowest set line wins
    function automatic logic [31:0] model_active(input logic [5:0] a);
        if (a == 6'd0) return 32'd0;
        for (int i = 0; i < 6; i++) begin
            if (a[i]) return 32'h8000_0000 | 32'(i);
        end
        return 32'd0;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        rdreg(2'd0, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_pend: got %h expected %h", v, 32'd0); end
        rdreg(2'd2, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_mode: got %h expected %h", v, 32'd0); end
        n_cmp++; if (interrupt !== 6'd0) begin n_bad++; $display("[TB] FAIL reset_int: got %h expected %h", interrupt, 6'd0); end
        wr(2'd1, 32'h1);
        irq_req = 6'h01;
        tick(5);
        n_cmp++; if (interrupt !== 6'h01) begin n_bad++; $display("[TB] FAIL pre_reset_int: got %h expected %h", interrupt, 6'h01); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (interrupt !== 6'd0) begin n_bad++; $display("[TB] FAIL async_reset_int: got %h expected %h", interrupt, 6'd0); end
        rdreg(2'd1, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("[TB] FAIL async_reset_mask: got %h expected %h", v, 32'd0); end
        rdreg(2'd3, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("[TB] FAIL async_reset_active: got %h expected %h", v, 32'd0); end
        irq_req = '0;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_edge();
        logic [31:0] v;
        logic        stayed_low;
        do_reset();
        wr(2'd1, 32'h01);
        wr(2'd2, 32'h01);
        irq_req = 6'h01;
        tick(1);
        irq_req = 6'h00;
        tick(2);
        n_cmp++; if (interrupt !== 6'h00) begin n_bad++; $display("[TB] FAIL edge_early: got %h expected %h", interrupt, 6'h00); end
        tick(1);
        n_cmp++; if (interrupt !== 6'h01) begin n_bad++; $display("[TB] FAIL edge_latency: got %h expected %h", interrupt, 6'h01); end
        exl = 1'b1;
        tick(1);
        n_cmp++; if (interrupt !== 6'h00) begin n_bad++; $display("[TB] FAIL edge_exl_drop: got %h expected %h", interrupt, 6'h00); end
        exl = 1'b0;
        tick(1);
        n_cmp++; if (interrupt !== 6'h00) begin n_bad++; $display("[TB] FAIL edge_exl_release: got %h expected %h", interrupt, 6'h00); end
        tick(1);
        n_cmp++; if (interrupt !== 6'h01) begin n_bad++; $display("[TB] FAIL edge_reassert: got %h expected %h", interrupt, 6'h01); end
        exl = 1'b1;
        tick(1);
        wr(2'd0, 32'h01);
        rdreg(2'd0, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("[TB] FAIL edge_w1c_pend: got %h expected %h", v, 32'd0); end
        exl = 1'b0;
        stayed_low = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (interrupt !== 6'h00) stayed_low = 1'b0;
        end
        n_cmp++; if (stayed_low !== 1'b1) begin n_bad++; $display("[TB] FAIL edge_after_w1c: got %b expected %b", stayed_low, 1'b1); end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'h3F);
        irq_req = 6'b100100;
        tick(5);
        rdreg(2'd3, v);
        n_cmp++; if (v !== 32'h8000_0002) begin n_bad++; $display("[TB] FAIL prio_active: got %h expected %h", v, 32'h8000_0002); end
        n_cmp++; if (interrupt !== 6'b100100) begin n_bad++; $display("[TB] FAIL prio_int: got %h expected %h", interrupt, 6'b100100); end
        wr(2'd0, 32'h3F);
        rdreg(2'd0, v);
        n_cmp++; if (v !== 32'h24) begin n_bad++; $display("[TB] FAIL level_w1c_ignored: got %h expected %h", v, 32'h24); end
    endtask

    task automatic test_timeout();
        int k  = 0;
        int hi = 0;
        int lo = 0;
        int hi2 = 0;
        do_reset();
        wr(2'd1, 32'h02);
        irq_req = 6'h02;
        while (interrupt === 6'h00 && k < 10) begin
            tick(1);
            k++;
        end
        n_cmp++; if (interrupt !== 6'h02) begin n_bad++; $display("[TB] FAIL tmo_first: got %h expected %h", interrupt, 6'h02); end
        while (interrupt !== 6'h00 && hi < 200) begin
            hi++;
            tick(1);
        end
        n_cmp++; if (hi !== 64) begin n_bad++; $display("[TB] FAIL tmo_high_cycles: got %0d expected %0d", hi, 64); end
        // One DROP cycle plus the IDLE cycle that re-evaluates the still-pending line
        while (interrupt === 6'h00 && lo < 10) begin
            lo++;
            tick(1);
        end
        n_cmp++; if (lo !== 2) begin n_bad++; $display("[TB] FAIL tmo_low_cycles: got %0d expected %0d", lo, 2); end
        n_cmp++; if (interrupt !== 6'h02) begin n_bad++; $display("[TB] FAIL tmo_reassert: got %h expected %h", interrupt, 6'h02); end
        while (interrupt !== 6'h00 && hi2 < 200) begin
            hi2++;
            tick(1);
        end
        n_cmp++; if (hi2 !== 64) begin n_bad++; $display("[TB] FAIL tmo_second_high: got %0d expected %0d", hi2, 64); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        do_reset();
        wr(2'd2, 32'h08);
        irq_req = 6'h08;
        tick(2);
        wr(2'd0, 32'h08);
        rdreg(2'd0, v);
        n_cmp++; if (v[3] !== 1'b1) begin n_bad++; $display("[TB] FAIL collision_set_wins: got %b expected %b", v[3], 1'b1); end
        wr(2'd0, 32'h08);
        rdreg(2'd0, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("[TB] FAIL collision_later_w1c: got %h expected %h", v, 32'd0); end
    endtask

    task automatic test_busy();
        logic stayed_low = 1'b1;
        int   k = 0;
        do_reset();
        wr(2'd1, 32'h20);
        exl     = 1'b1;
        irq_req = 6'h20;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (interrupt !== 6'h00) stayed_low = 1'b0;
        end
        n_cmp++; if (stayed_low !== 1'b1) begin n_bad++; $display("[TB] FAIL busy_held_off: got %b expected %b", stayed_low, 1'b1); end
        exl = 1'b0;
        while (interrupt[5] !== 1'b1 && k < 2) begin
            tick(1);
            k++;
        end
        n_cmp++; if (interrupt !== 6'h20) begin n_bad++; $display("[TB] FAIL busy_release: got %h expected %h", interrupt, 6'h20); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] w;
        logic [5:0]  m;
        logic [5:0]  r;
        logic [5:0]  p;
        logic [5:0]  pend_model;
        do_reset();
        exl = 1'b1;
        // Level mode: pending mirrors the held requests, ACTIVE follows the priority rule
        for (int it = 0; it < 16; it++) begin
            w = $urandom;
            m = w[5:0];
            r = 6'($urandom);
            wr(2'd1, w);
            irq_req = r;
            tick(4);
            rdreg(2'd1, v);
            n_cmp++; if (v !== {26'd0, m}) begin n_bad++; $display("[TB] FAIL rnd_mask it%0d: got %h expected %h", it, v, {26'd0, m}); end
            rdreg(2'd0, v);
            n_cmp++; if (v !== {26'd0, r}) begin n_bad++; $display("[TB] FAIL rnd_level_pend it%0d: got %h expected %h", it, v, {26'd0, r}); end
            rdreg(2'd3, v);
            n_cmp++; if (v !== model_active(r & m)) begin n_bad++; $display("[TB] FAIL rnd_active it%0d: got %h expected %h", it, v, model_active(r & m)); end
            n_cmp++; if (interrupt !== 6'h00) begin n_bad++; $display("[TB] FAIL rnd_busy_int it%0d: got %h expected %h", it, interrupt, 6'h00); end
        end
        // Edge mode: pending accumulates pulses and is cleared only by W1C
        irq_req = '0;
        tick(4);
        wr(2'd2, 32'hFFFF_FFFF);
        rdreg(2'd2, v);
        n_cmp++; if (v !== 32'h3F) begin n_bad++; $display("[TB] FAIL rnd_mode_rw: got %h expected %h", v, 32'h3F); end
        pend_model = '0;
        for (int it = 0; it < 12; it++) begin
            p = 6'($urandom);
            irq_req = p;
            tick(1);
            irq_req = '0;
            tick(4);
            pend_model = pend_model | p;
            rdreg(2'd0, v);
            n_cmp++; if (v !== {26'd0, pend_model}) begin n_bad++; $display("[TB] FAIL rnd_edge_set it%0d: got %h expected %h", it, v, {26'd0, pend_model}); end
            w = $urandom;
            wr(2'd0, w);
            pend_model = pend_model & ~w[5:0];
            rdreg(2'd0, v);
            n_cmp++; if (v !== {26'd0, pend_model}) begin n_bad++; $display("[TB] FAIL rnd_edge_w1c it%0d: got %h expected %h", it, v, {26'd0, pend_model}); end
        end
        pend_model = 6'h3F;
        irq_req = 6'h3F;
        tick(1);
        irq_req = '0;
        tick(4);
        wr(2'd2, 32'hFFFF_FFC0 | 32'h3F);
        wr(2'd3, 32'hFFFF_FFFF);
        rdreg(2'd0, v);
        n_cmp++; if (v !== {26'd0, pend_model}) begin n_bad++; $display("[TB] FAIL mode_write_keeps_pend: got %h expected %h", v, {26'd0, pend_model}); end
        exl = 1'b0;
    endtask

    // Global safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence and final summary
    initial begin
        test_reset();
        test_edge();
        test_priority();
        test_timeout();
        test_collision();
        test_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
